nco_clock_gen: RTL and testbench

Parametrised, runtime-reconfigurable clock-enable generator for the composite-video pipeline. It runs N independent numerically controlled oscillators (NCOs) from the single PLL output clock. Each channel produces a single-cycle `clken` strobe at a fractional rate of `refclk` and exposes its coarse phase, for example for a colour-subcarrier or pixel-rate enable. A `locked` output mimics PLL lock semantics: it is deasserted during settling after reset and after every rate change.

---
 rtl/nco_pkg.sv | 26 ++
 rtl/nco_channel.sv | 65 ++++++
 rtl/nco_clock_gen.sv | 141 ++++++++++++++
 tb/tb_nco_clock_gen.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nco_pkg
// Description : Shared types and helpers for the NCO clock-enable generator.
//               - nco_state_t    : lock/apply state machine encoding
//               - NCO_PHASE_BITS : width of the coarse phase slice per channel
//               - nco_cw()       : channel-select width, max(1, clog2(n))
// Revision    : 1.0 - initial release
// ============================================================================
package nco_pkg;

  localparam int NCO_PHASE_BITS = 8;

  typedef enum logic [1:0] {
    LOCKING = 2'd0,
    LOCKED  = 2'd1,
    APPLY   = 2'd2
  } nco_state_t;

  // Width of a select field for n items; never narrower than one bit.
  function automatic int nco_cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage : nco_pkg
`default_nettype wire

// File: rtl/nco_channel.sv
`default_nettype none
// ============================================================================
// Module      : nco_channel
// Description : One numerically controlled oscillator. Holds the phase
//               accumulator, its increment register and the registered carry.
//               Each cycle {carry, acc} <= acc + inc (ACC_WIDTH+1 bits).
// Ports       : refclk    - clock (rising edge)
//               reset     - synchronous active-high reset
//               load_en   - write load_inc into the increment register
//               load_inc  - new increment value
//               clear_acc - with load_en, also zero the accumulator
//               carry     - registered accumulator carry (ungated)
//               phase     - top NCO_PHASE_BITS of the accumulator
// Revision    : 1.0 - initial release
// ============================================================================
module nco_channel
  import nco_pkg::*;
#(
  parameter int                   ACC_WIDTH      = 32,
  parameter logic [ACC_WIDTH-1:0] INIT_INCREMENT = ACC_WIDTH'(32'h1000_0000)
) (
  input  logic                      refclk,
  input  logic                      reset,
  input  logic                      load_en,
  input  logic [ACC_WIDTH-1:0]      load_inc,
  input  logic                      clear_acc,
  output logic                      carry,
  output logic [NCO_PHASE_BITS-1:0] phase
);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] inc_q, inc_d;
  logic                 carry_q, carry_d;

  always_comb begin
    // The accumulator always advances with the increment in force this
    // cycle; a newly loaded increment only takes effect on the next edge.
    {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, inc_q};
    inc_d            = inc_q;
    if (load_en) begin
      inc_d = load_inc;
      if (clear_acc) begin
        acc_d   = '0;
        carry_d = 1'b0;
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (reset) begin
      acc_q   <= '0;
      inc_q   <= INIT_INCREMENT;
      carry_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      inc_q   <= inc_d;
      carry_q <= carry_d;
    end
  end

  assign carry = carry_q;
  assign phase = acc_q[ACC_WIDTH-1 -: NCO_PHASE_BITS];

endmodule : nco_channel
`default_nettype wire

// File: rtl/nco_clock_gen.sv
`default_nettype none
// ============================================================================
// Module      : nco_clock_gen
// Description : Multi-channel NCO clock-enable generator with PLL-style lock
//               indication. Holds the LOCKING/LOCKED/APPLY state machine,
//               the settle counter and the rate-update decode; instantiates
//               CHANNELS x nco_channel.
// Ports       : refclk        - sole clock (rising edge)
//               reset         - synchronous active-high reset
//               cfg_valid     - rate update request
//               cfg_ready     - update can be accepted
//               cfg_channel   - target channel of the update
//               cfg_increment - new phase increment
//               clken         - per-channel enable strobes (gated by locked)
//               phase         - per-channel coarse phase, 8 bits each
//               locked        - outputs stable and valid
// Options     : NCO_PHASE_RESET_EN - when defined, applying a new increment
//               also zeroes the target channel's accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module nco_clock_gen
  import nco_pkg::*;
#(
  parameter int                   CHANNELS       = 2,
  parameter int                   ACC_WIDTH      = 32,
  parameter logic [ACC_WIDTH-1:0] INIT_INCREMENT = ACC_WIDTH'(32'h1000_0000),
  parameter int                   LOCK_CYCLES    = 16
) (
  input  logic                               refclk,
  input  logic                               reset,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  input  logic [nco_cw(CHANNELS)-1:0]        cfg_channel,
  input  logic [ACC_WIDTH-1:0]               cfg_increment,
  output logic [CHANNELS-1:0]                clken,
  output logic [NCO_PHASE_BITS*CHANNELS-1:0] phase,
  output logic                               locked
);

  localparam int CW    = nco_cw(CHANNELS);
  localparam int CNT_W = nco_cw(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

`ifdef NCO_PHASE_RESET_EN
  localparam logic PHASE_RESET = 1'b1;
`else
  localparam logic PHASE_RESET = 1'b0;
`endif

  nco_state_t           state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CW-1:0]        pend_chan_q, pend_chan_d;
  logic [ACC_WIDTH-1:0] pend_inc_q, pend_inc_d;
  logic                 locked_q, locked_d;

  logic                 chan_ok;
  logic                 accept;
  logic [CHANNELS-1:0]  carry_w;

  assign cfg_ready = !reset && (state_q != APPLY);
  assign chan_ok   = (int'({1'b0, cfg_channel}) < CHANNELS);
  // Out-of-range targets complete the handshake but change nothing.
  assign accept    = cfg_valid && cfg_ready && chan_ok;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    pend_chan_d = pend_chan_q;
    pend_inc_d  = pend_inc_q;
    unique case (state_q)
      LOCKING: begin
        if (accept) begin
          state_d     = APPLY;
          pend_chan_d = cfg_channel;
          pend_inc_d  = cfg_increment;
        end else if (count_q == CNT_LAST) begin
          state_d = LOCKED;
          count_d = '0;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      LOCKED: begin
        if (accept) begin
          state_d     = APPLY;
          pend_chan_d = cfg_channel;
          pend_inc_d  = cfg_increment;
        end
      end
      APPLY: begin
        state_d = LOCKING;
        count_d = '0;
      end
      default: begin
        state_d = LOCKING;
        count_d = '0;
      end
    endcase
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge refclk) begin
    if (reset) begin
      state_q     <= LOCKING;
      count_q     <= '0;
      pend_chan_q <= '0;
      pend_inc_q  <= '0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      pend_chan_q <= pend_chan_d;
      pend_inc_q  <= pend_inc_d;
      locked_q    <= locked_d;
    end
  end

  assign locked = locked_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
    logic load_en;
    assign load_en = (state_q == APPLY) && (pend_chan_q == CW'(i));

    nco_channel #(
      .ACC_WIDTH      (ACC_WIDTH),
      .INIT_INCREMENT (INIT_INCREMENT)
    ) u_channel (
      .refclk    (refclk),
      .reset     (reset),
      .load_en   (load_en),
      .load_inc  (pend_inc_q),
      .clear_acc (PHASE_RESET),
      .carry     (carry_w[i]),
      .phase     (phase[NCO_PHASE_BITS*i +: NCO_PHASE_BITS])
    );

    assign clken[i] = carry_w[i] & locked_q;
  end : g_channel

endmodule : nco_clock_gen
`default_nettype wire

// File: tb/tb_nco_clock_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_nco_clock_gen
// Description : Scoreboard bench for nco_clock_gen (3 channels, 8-bit
//               accumulators, INIT 64, 4 settle cycles). A driver applies
//               directed then random stimulus and pushes the reference
//               model's expected outputs; a monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nco_clock_gen;

  localparam int CH   = 3;
  localparam int AW   = 8;
  localparam int INIT = 64;
  localparam int LC   = 4;
  localparam int CW   = 2;
  localparam int MOD  = 1 << AW;

  logic              refclk = 1'b0;
  logic              reset  = 1'b1;
  logic              cfg_valid = 1'b0;
  logic [CW-1:0]     cfg_channel = '0;
  logic [AW-1:0]     cfg_increment = '0;
  logic              cfg_ready;
  logic [CH-1:0]     clken;
  logic [8*CH-1:0]   phase;
  logic              locked;

  always #5 refclk = ~refclk;

  nco_clock_gen #(
    .CHANNELS       (CH),
    .ACC_WIDTH      (AW),
    .INIT_INCREMENT (AW'(INIT)),
    .LOCK_CYCLES    (LC)
  ) dut (
    .refclk        (refclk),
    .reset         (reset),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_channel   (cfg_channel),
    .cfg_increment (cfg_increment),
    .clken         (clken),
    .phase         (phase),
    .locked        (locked)
  );

  typedef struct {
    logic [CH-1:0]   clken;
    logic [8*CH-1:0] phase;
    logic            locked;
    logic            ready;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: integer phase sums per channel plus absolute edge
  // numbers at which lock is regained and a pending update lands.
  int m_acc[CH];
  int m_inc[CH];
  bit m_carry[CH];
  int cyc       = 0;
  int locked_at = 1 << 30;
  int apply_at  = -1;
  int p_ch      = 0;
  int p_inc     = 0;

  task automatic model_edge();
    cyc++;
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        m_acc[i]   = 0;
        m_inc[i]   = INIT;
        m_carry[i] = 1'b0;
      end
      apply_at  = -1;
      locked_at = cyc + LC;
    end else begin
      for (int i = 0; i < CH; i++) begin
        int s;
        s          = m_acc[i] + m_inc[i];
        m_carry[i] = (s >= MOD);
        m_acc[i]   = s % MOD;
      end
      if (apply_at == cyc) begin
        m_inc[p_ch] = p_inc;
`ifdef NCO_PHASE_RESET_EN
        m_acc[p_ch]   = 0;
        m_carry[p_ch] = 1'b0;
`endif
        apply_at = -1;
      end else if (cfg_valid && int'(cfg_channel) < CH) begin
        apply_at  = cyc + 1;
        p_ch      = int'(cfg_channel);
        p_inc     = int'(cfg_increment);
        locked_at = cyc + 1 + LC;
      end
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.locked = (cyc >= locked_at);
    e.ready  = !reset && (apply_at != cyc + 1);
    for (int i = 0; i < CH; i++) begin
      e.clken[i]       = m_carry[i] && e.locked;
      e.phase[8*i +: 8] = 8'(m_acc[i]);
    end
    exp_q.push_back(e);
  endtask

  // One clock: the model consumes the inputs held this cycle, then the
  // inputs for the next cycle are applied and the expected outputs queued.
  task automatic drive(input bit r, input bit v, input int c, input int n);
    @(posedge refclk);
    model_edge();
    #1;
    reset         = r;
    cfg_valid     = v;
    cfg_channel   = CW'(c);
    cfg_increment = AW'(n);
    push_expected();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 0, 0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge refclk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (locked !== e.locked) begin
          n_bad++;
          $display("FAIL locked @%0d: got %b want %b", cyc, locked, e.locked);
        end
        n_cmp++;
        if (cfg_ready !== e.ready) begin
          n_bad++;
          $display("FAIL cfg_ready @%0d: got %b want %b", cyc, cfg_ready, e.ready);
        end
        n_cmp++;
        if (clken !== e.clken) begin
          n_bad++;
          $display("FAIL clken @%0d: got %b want %b", cyc, clken, e.clken);
        end
        n_cmp++;
        if (phase !== e.phase) begin
          n_bad++;
          $display("FAIL phase @%0d: got %h want %h", cyc, phase, e.phase);
        end
      end
    end
  end

  // Driver
  initial begin
    bit r, v;
    int c, k, n;

    // Reset, release, lock and free-run at INIT rate.
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    idle(14);

    // Rate change on ch1.
    drive(0, 1, 1, 128);
    idle(12);

    // Out-of-range channel: handshake ignored.
    drive(0, 1, 3, 1);
    idle(8);

    // Freeze ch0.
    drive(0, 1, 0, 0);
    idle(10);

    // Reset two cycles into LOCKING after an update.
    drive(0, 1, 1, 200);
    idle(2);
    drive(1, 0, 0, 0);
    idle(10);

    // Reset while in APPLY discards the update.
    drive(0, 1, 2, 9);
    drive(1, 0, 0, 0);
    idle(8);

    // Valid held across APPLY; maximal increment on ch2.
    drive(0, 1, 2, 255);
    drive(0, 1, 2, 255);
    drive(0, 1, 2, 255);
    idle(12);

    // Random traffic.
    for (int t = 0; t < 600; t++) begin
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 5) == 0);
      c = int'($urandom_range(0, 3));
      k = int'($urandom_range(0, 9));
      if (k == 0)      n = 0;
      else if (k == 1) n = MOD - 1;
      else             n = int'($urandom_range(0, MOD - 1));
      drive(r, v, c, n);
    end
    idle(8);

    // Let the monitor drain, bounded.
    repeat (3) @(negedge refclk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_nco_clock_gen
`default_nettype wire
